// File: rtl/sram_pkg.sv
// sram_pkg: shared types, constants and address
// helpers for the instruction/data SRAM responders.
package sram_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    CLEAR,
    RUN
  } sram_state_e;

  // Byte offset of a CPU address from the window base.
  function automatic logic [31:0] addr_off(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return addr - base;
  endfunction

  // Offset lies inside a window of 2**aw words.
  // Addresses below base wrap to huge offsets and
  // therefore fall outside the window.
  function automatic logic addr_in_win(
    input logic [31:0] off,
    input int unsigned aw
  );
    logic [32:0] lim;
    lim = 33'd4 << aw;
    return {1'b0, off} < lim;
  endfunction

endpackage

// File: rtl/sram_1rw_array.sv
// sram_1rw_array: plain 1-write/1-read word storage, read-first.
// Ports: we/waddr/wdata write, re/raddr read, rclr zeroes rdata.
module sram_1rw_array
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_d;
  logic [WORD_W-1:0] rdata_q;

  // mem is sampled before this edge's write lands,
  // so a same-word read returns the old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (rclr) begin
      rdata_d = ZERO_WORD;
    end else if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_sram.sv
// inst_sram: CPU instruction SRAM with loader port and reset clear.
// Ports: CPU en/wen/addr/wdata/rdata, ld_* loader, busy, err_* flags.
module inst_sram
  import sram_pkg::*;
#(
  parameter int          ADDR_W         = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic              inst_sram_wen,
  input  logic [31:0]       inst_sram_addr,
  input  logic [31:0]       inst_sram_write_data,
  output logic [31:0]       inst_sram_read_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              busy,
  output logic              err_range,
  output logic              err_align
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  sram_state_e       state_d, state_q;
  logic [ADDR_W-1:0] clr_ptr_d, clr_ptr_q;
  logic              err_range_d, err_range_q;
  logic              err_align_d, err_align_q;

  logic [31:0]       off;
  logic              in_win;
  logic [ADDR_W-1:0] cpu_idx;
  logic              run;
  logic              cpu_acc;
  logic              clr_wr, ld_wr, cpu_wr;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              re;
  logic              rclr;

  assign off     = addr_off(inst_sram_addr, BASE_ADDR);
  assign in_win  = addr_in_win(off, ADDR_W);
  assign cpu_idx = off[ADDR_W+1:2];

  assign run     = (state_q == RUN);
  assign cpu_acc = run & inst_sram_en & ~rst;

  assign ld_ready = run;
  assign busy     = (state_q == CLEAR);

  // Write sources are made mutually exclusive here:
  // the loader beats a same-cycle CPU write.
  assign clr_wr = ~run & ~rst;
  assign ld_wr  = run & ~rst & ld_valid;
  assign cpu_wr = cpu_acc & ~ld_valid
                & inst_sram_wen & in_win;

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    err_range_d = err_range_q;
    err_align_d = err_align_q;
    if (rst) begin
      state_d     = CLEAR_ON_RESET ? CLEAR : RUN;
      clr_ptr_d   = '0;
      err_range_d = 1'b0;
      err_align_d = 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_ptr_d = clr_ptr_q + PTR_ONE;
          if (&clr_ptr_q) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (inst_sram_en) begin
            err_range_d = err_range_q | ~in_win;
            err_align_d = err_align_q
                        | (|inst_sram_addr[1:0]);
          end
        end
      endcase
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = clr_ptr_q;
    wdata = ZERO_WORD;
    unique case (1'b1)
      clr_wr: begin
        we = 1'b1;
      end
      ld_wr: begin
        we    = 1'b1;
        waddr = ld_addr;
        wdata = ld_data;
      end
      cpu_wr: begin
        we    = 1'b1;
        waddr = cpu_idx;
        wdata = inst_sram_write_data;
      end
      default: ;
    endcase
  end

  // Reads and writes both return the word's old value;
  // out-of-window accesses and reset return zero.
  assign re   = cpu_acc & in_win;
  assign rclr = rst | (cpu_acc & ~in_win);

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    clr_ptr_q   <= clr_ptr_d;
    err_range_q <= err_range_d;
    err_align_q <= err_align_d;
  end

  sram_1rw_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .rclr (rclr),
    .raddr(cpu_idx),
    .rdata(inst_sram_read_data)
  );

  assign err_range = err_range_q;
  assign err_align = err_align_q;

endmodule

// File: tb/tb_inst_sram.sv
// tb_inst_sram: scoreboard bench for inst_sram, ADDR_W=4.
// Expected read data is queued at drive time, popped at output.
module tb_inst_sram;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_sram_en;
  logic          inst_sram_wen;
  logic [31:0]   inst_sram_addr;
  logic [31:0]   inst_sram_write_data;
  logic [31:0]   inst_sram_read_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          busy;
  logic          err_range;
  logic          err_align;

  always #5 clk = ~clk;

  inst_sram #(
    .ADDR_W        (AW),
    .BASE_ADDR     (32'h0000_0000),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_sram_en        (inst_sram_en),
    .inst_sram_wen       (inst_sram_wen),
    .inst_sram_addr      (inst_sram_addr),
    .inst_sram_write_data(inst_sram_write_data),
    .inst_sram_read_data (inst_sram_read_data),
    .ld_valid            (ld_valid),
    .ld_ready            (ld_ready),
    .ld_addr             (ld_addr),
    .ld_data             (ld_data),
    .busy                (busy),
    .err_range           (err_range),
    .err_align           (err_align)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] model [16];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic idle_in;
    inst_sram_en         = 1'b0;
    inst_sram_wen        = 1'b0;
    inst_sram_addr       = '0;
    inst_sram_write_data = '0;
    ld_valid             = 1'b0;
    ld_addr              = '0;
    ld_data              = '0;
  endtask

  // One cycle of CPU and/or loader activity, called at negedge.
  task automatic cpu_op(
    input string         tag,
    input logic          en,
    input logic          wen,
    input logic [31:0]   a,
    input logic [31:0]   d,
    input logic          ld,
    input logic [AW-1:0] la,
    input logic [31:0]   ldd
  );
    logic [31:0]   e;
    logic          inr;
    logic [AW-1:0] idx;
    inr = (a < 32'd64);
    idx = a[AW+1:2];
    e   = last_rd;
    if (en) e = inr ? model[idx] : 32'h0;
    if (ld) model[la] = ldd;
    else if (en && wen && inr) model[idx] = d;
    exp_q.push_back(e);
    last_rd = e;
    inst_sram_en         = en;
    inst_sram_wen        = wen;
    inst_sram_addr       = a;
    inst_sram_write_data = d;
    ld_valid             = ld;
    ld_addr              = la;
    ld_data              = ldd;
    if (ld) check_eq({tag, "_rdy"}, 32'(ld_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    check_eq(tag, inst_sram_read_data, exp_q.pop_front());
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy && cnt < 100) begin
      check_eq({tag, "_ldrdy"}, 32'(ld_ready), 32'd0);
      cnt++;
      @(negedge clk);
    end
    check_eq({tag, "_len"}, cnt, 32'd16);
  endtask

  initial begin
    idle_in();
    rst     = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rd", inst_sram_read_data, 32'h0);
    check_eq("rst_erng", 32'(err_range), 32'd0);
    check_eq("rst_eal", 32'(err_align), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    count_busy("clr0");

    for (int i = 0; i < 16; i++)
      cpu_op("zero_rd", 1, 0, 32'(i * 4), 0, 0, 0, 0);

    begin
      logic [31:0] prog [4];
      prog[0] = 32'h2001_0005;
      prog[1] = 32'h2002_0007;
      prog[2] = 32'h0022_1820;
      prog[3] = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
        ld_valid = 1'b1;
        ld_addr  = AW'(i);
        ld_data  = prog[i];
        check_eq("ld_burst_rdy", 32'(ld_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        model[i] = prog[i];
      end
      idle_in();
      check_eq("ld_no_rd", inst_sram_read_data, last_rd);
    end

    cpu_op("rd0", 1, 0, 32'h0, 0, 0, 0, 0);
    cpu_op("rd4", 1, 0, 32'h4, 0, 0, 0, 0);
    cpu_op("rd8", 1, 0, 32'h8, 0, 0, 0, 0);

    cpu_op("wr8_old", 1, 1, 32'h8, 32'hDEAD_BEEF, 0, 0, 0);
    cpu_op("rd8_new", 1, 0, 32'h8, 0, 0, 0, 0);

    cpu_op("coll_old", 1, 1, 32'h4, 32'h2222_2222,
           1, 4'd1, 32'h1111_1111);
    cpu_op("coll_rd", 1, 0, 32'h4, 0, 0, 0, 0);

    cpu_op("ldrd_old", 1, 0, 32'h8, 0, 1, 4'd2, 32'hCAFE_0001);
    cpu_op("ldrd_new", 1, 0, 32'h8, 0, 0, 0, 0);

    cpu_op("hold", 0, 0, 32'h0, 0, 0, 0, 0);

    check_eq("erng_pre", 32'(err_range), 32'd0);
    check_eq("eal_pre", 32'(err_align), 32'd0);
    cpu_op("oor_rd", 1, 0, 32'h40, 0, 0, 0, 0);
    check_eq("erng_set", 32'(err_range), 32'd1);
    check_eq("eal_clr", 32'(err_align), 32'd0);
    cpu_op("mis_rd", 1, 0, 32'h6, 0, 0, 0, 0);
    check_eq("eal_set", 32'(err_align), 32'd1);
    check_eq("erng_stk", 32'(err_range), 32'd1);
    cpu_op("oor_wr", 1, 1, 32'h44, 32'hBAD0_BAD0, 0, 0, 0);
    cpu_op("oor_drop", 1, 0, 32'h4, 0, 0, 0, 0);
    check_eq("erng_stk2", 32'(err_range), 32'd1);
    cpu_op("blw_base", 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0);

    pulse_rst();
    repeat (7) @(negedge clk);
    check_eq("mid_busy", 32'(busy), 32'd1);
    pulse_rst();
    count_busy("clr1");
    check_eq("clr1_rd", inst_sram_read_data, 32'h0);
    check_eq("clr1_erng", 32'(err_range), 32'd0);
    check_eq("clr1_eal", 32'(err_align), 32'd0);
    cpu_op("lost_rd4", 1, 0, 32'h4, 0, 0, 0, 0);
    cpu_op("lost_rd0", 1, 0, 32'h0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
